// File: rtl/input_command_ctrl_pkg.sv
// Shared types and constants for the PS/2 keyboard to game-command path.
package input_pkg;

    typedef enum logic [1:0] {
        READY = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        OVER  = 2'd3
    } game_state_t;

    typedef enum logic [1:0] {
        P_IDLE    = 2'd0,
        P_BRK     = 2'd1,
        P_EXT     = 2'd2,
        P_EXT_BRK = 2'd3
    } prefix_state_t;

    localparam logic [7:0] CODE_BRK = 8'hF0;
    localparam logic [7:0] CODE_EXT = 8'hE0;

    localparam logic [7:0] DEF_KEY_SPACE = 8'h29;
    localparam logic [7:0] DEF_KEY_PAUSE = 8'h4D;
    localparam logic [7:0] DEF_KEY_ENTER = 8'h5A;

endpackage

// File: rtl/input_command_ctrl_if.sv
// Byte stream in, game commands and status out.
// code_valid is a one-cycle strobe with no ready: every byte is accepted, back-to-back included.
interface input_command_ctrl_if;

    logic       code_valid;
    logic [7:0] code;
    logic       game_over;
    logic       flap;
    logic       start;
    logic       restart;
    logic       running;
    logic       paused;
    logic       space_held;
    logic [1:0] state;
    logic [1:0] prefix_state;

    modport master (
        output code_valid, code, game_over,
        input  flap, start, restart, running, paused, space_held, state, prefix_state
    );

    modport slave (
        input  code_valid, code, game_over,
        output flap, start, restart, running, paused, space_held, state, prefix_state
    );

endinterface

// File: rtl/input_command_ctrl_ps2_code_decoder.sv
// Make/break/extended prefix decoder with per-key held flags; press strobes are
// combinational in the code_valid cycle and filter out typematic repeats.
module ps2_code_decoder
    import input_pkg::*;
#(
    parameter logic [7:0] KEY_SPACE = DEF_KEY_SPACE,
    parameter logic [7:0] KEY_PAUSE = DEF_KEY_PAUSE,
    parameter logic [7:0] KEY_ENTER = DEF_KEY_ENTER
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          code_valid,
    input  logic [7:0]    code,
    output logic          press_space,
    output logic          press_pause,
    output logic          press_enter,
    output logic          space_held,
    output prefix_state_t pstate
);

    prefix_state_t pstate_q, pstate_d;
    logic          is_make, is_break;
    logic          space_q, pause_q, enter_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pstate_q <= P_IDLE;
            space_q  <= 1'b0;
            pause_q  <= 1'b0;
            enter_q  <= 1'b0;
        end else begin
            pstate_q <= pstate_d;
            if (is_make && code == KEY_SPACE)  space_q <= 1'b1;
            if (is_break && code == KEY_SPACE) space_q <= 1'b0;
            if (is_make && code == KEY_PAUSE)  pause_q <= 1'b1;
            if (is_break && code == KEY_PAUSE) pause_q <= 1'b0;
            if (is_make && code == KEY_ENTER)  enter_q <= 1'b1;
            if (is_break && code == KEY_ENTER) enter_q <= 1'b0;
        end
    end

    // Extended sequences fall back to P_IDLE without ever raising is_make/is_break.
    always_comb begin
        pstate_d = pstate_q;
        is_make  = 1'b0;
        is_break = 1'b0;
        if (code_valid) begin
            case (pstate_q)
                P_IDLE: begin
                    if (code == CODE_BRK)      pstate_d = P_BRK;
                    else if (code == CODE_EXT) pstate_d = P_EXT;
                    else                       is_make  = 1'b1;
                end
                P_BRK: begin
                    is_break = 1'b1;
                    pstate_d = P_IDLE;
                end
                P_EXT:     pstate_d = (code == CODE_BRK) ? P_EXT_BRK : P_IDLE;
                P_EXT_BRK: pstate_d = P_IDLE;
                default:   pstate_d = P_IDLE;
            endcase
        end
    end

    assign press_space = is_make && code == KEY_SPACE && !space_q;
    assign press_pause = is_make && code == KEY_PAUSE && !pause_q;
    assign press_enter = is_make && code == KEY_ENTER && !enter_q;
    assign space_held  = space_q;
    assign pstate      = pstate_q;

endmodule

// File: rtl/input_command_ctrl.sv
// Game-level FSM (READY/RUN/PAUSE/OVER) and flap cooldown on top of the
// scancode decoder; all command pulses are registered, one cycle after the byte.
module input_command_ctrl
    import input_pkg::*;
#(
    parameter int         COOLDOWN_CYC = 2500000,
    parameter logic [7:0] KEY_SPACE    = DEF_KEY_SPACE,
    parameter logic [7:0] KEY_PAUSE    = DEF_KEY_PAUSE,
    parameter logic [7:0] KEY_ENTER    = DEF_KEY_ENTER
) (
    input  logic          clk,
    input  logic          reset,
    input_command_ctrl_if.slave bus
);

    localparam int            CW      = $clog2(COOLDOWN_CYC + 1);
    localparam logic [CW-1:0] CD_LOAD = CW'(COOLDOWN_CYC - 1);

    logic          press_space, press_pause, press_enter, space_held;
    prefix_state_t pstate;

    game_state_t   gstate_q, gstate_d;
    logic [CW-1:0] cd_q, cd_d;
    logic          flap_q, flap_d, start_q, start_d, restart_q, restart_d;

    ps2_code_decoder #(
        .KEY_SPACE (KEY_SPACE),
        .KEY_PAUSE (KEY_PAUSE),
        .KEY_ENTER (KEY_ENTER)
    ) u_decoder (
        .clk         (clk),
        .reset       (reset),
        .code_valid  (bus.code_valid),
        .code        (bus.code),
        .press_space (press_space),
        .press_pause (press_pause),
        .press_enter (press_enter),
        .space_held  (space_held),
        .pstate      (pstate)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            gstate_q  <= READY;
            cd_q      <= '0;
            flap_q    <= 1'b0;
            start_q   <= 1'b0;
            restart_q <= 1'b0;
        end else begin
            gstate_q  <= gstate_d;
            cd_q      <= cd_d;
            flap_q    <= flap_d;
            start_q   <= start_d;
            restart_q <= restart_d;
        end
    end

    // A collision in RUN wins over any key decoded in the same cycle.
    always_comb begin
        gstate_d  = gstate_q;
        flap_d    = 1'b0;
        start_d   = 1'b0;
        restart_d = 1'b0;
        cd_d      = (cd_q == '0) ? '0 : cd_q - CW'(1);
        case (gstate_q)
            READY: begin
                if (press_space) begin
                    start_d  = 1'b1;
                    gstate_d = RUN;
                end
            end
            RUN: begin
                if (bus.game_over) begin
                    gstate_d = OVER;
                end else if (press_space) begin
                    if (cd_q == '0) begin
                        flap_d = 1'b1;
                        cd_d   = CD_LOAD;
                    end
                end else if (press_pause) begin
                    gstate_d = PAUSE;
                end
            end
            PAUSE: begin
                if (press_pause) gstate_d = RUN;
            end
            OVER: begin
                if (press_enter) begin
                    restart_d = 1'b1;
                    gstate_d  = READY;
                end
            end
            default: gstate_d = READY;
        endcase
    end

    assign bus.flap         = flap_q;
    assign bus.start        = start_q;
    assign bus.restart      = restart_q;
    assign bus.running      = (gstate_q == RUN);
    assign bus.paused       = (gstate_q == PAUSE);
    assign bus.space_held   = space_held;
    assign bus.state        = gstate_q;
    assign bus.prefix_state = pstate;

endmodule

// File: tb/tb_input_command_ctrl.sv
// Bench for input_command_ctrl: directed vector table, reset-mid-prefix sequence,
// then random byte streams checked against a behavioural keyboard/game model.
module tb_input_command_ctrl;

    localparam int COOL = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    input_command_ctrl_if bus ();

    input_command_ctrl #(.COOLDOWN_CYC(COOL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int vectors = 0;
    int miscompares = 0;

    // expected = {flap, start, restart, state[1:0], space_held}
    typedef struct {
        logic       v;
        logic [7:0] c;
        logic       go;
        logic [5:0] exp;
        int         idle;
    } vec_t;

    vec_t tbl[$];
    logic [5:0] exp_q[$];

    function automatic vec_t row(input logic v, input logic [7:0] c, input logic go,
                                 input logic fl, input logic st, input logic rs,
                                 input logic [1:0] gs, input logic held, input int idle);
        vec_t r;
        r.v = v; r.c = c; r.go = go;
        r.exp = {fl, st, rs, gs, held};
        r.idle = idle;
        return r;
    endfunction

    task automatic check(input logic [5:0] exp, input int exp_idle, input string name);
        logic [7:0] act, full;
        bit ok;
        act  = {bus.flap, bus.start, bus.restart, bus.state, bus.space_held, bus.running, bus.paused};
        full = {exp, exp[2:1] == 2'd1, exp[2:1] == 2'd2};
        ok   = (act === full);
        if (exp_idle >= 0 && ((exp_idle == 1) != (bus.prefix_state == 2'd0))) ok = 1'b0;
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s: got {flap,start,restart,state,held,run,pause}=%b prefix=%0d, want %b idle=%0d",
                     name, act, bus.prefix_state, full, exp_idle);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] c, input logic go,
                        input logic [5:0] exp, input int exp_idle, input string name);
        bus.code_valid = v;
        bus.code       = c;
        bus.game_over  = go;
        @(posedge clk);
        #1;
        bus.code_valid = 1'b0;
        bus.game_over  = 1'b0;
        check(exp, exp_idle, name);
    endtask

    // ---------------- behavioural model ----------------
    bit      m_brk, m_ext;
    bit      m_held[256];
    int      m_state;
    longint  m_cyc, m_last_flap;
    bit      m_flap, m_start, m_restart;

    task automatic model_reset();
        m_brk = 0; m_ext = 0;
        foreach (m_held[i]) m_held[i] = 0;
        m_state = 0;
        m_last_flap = -1000;
        m_flap = 0; m_start = 0; m_restart = 0;
    endtask

    task automatic model_step(input logic v, input logic [7:0] c, input logic go);
        bit mk, fresh, sp, pz, en;
        mk = 0; fresh = 0;
        m_flap = 0; m_start = 0; m_restart = 0;
        if (v) begin
            if (m_ext) begin
                if (m_brk) begin m_ext = 0; m_brk = 0; end
                else if (c == 8'hF0) m_brk = 1;
                else m_ext = 0;
            end else if (m_brk) begin
                m_held[c] = 0;
                m_brk = 0;
            end else if (c == 8'hF0) m_brk = 1;
            else if (c == 8'hE0) m_ext = 1;
            else begin
                mk = 1;
                fresh = !m_held[c];
                m_held[c] = 1;
            end
        end
        sp = mk && fresh && c == 8'h29;
        pz = mk && fresh && c == 8'h4D;
        en = mk && fresh && c == 8'h5A;
        case (m_state)
            0: if (sp) begin m_start = 1; m_state = 1; end
            1: begin
                if (go) m_state = 3;
                else if (sp) begin
                    if (m_cyc - m_last_flap >= COOL) begin
                        m_flap = 1;
                        m_last_flap = m_cyc;
                    end
                end else if (pz) m_state = 2;
            end
            2: if (pz) m_state = 1;
            default: if (en) begin m_restart = 1; m_state = 0; end
        endcase
        m_cyc++;
    endtask

    task automatic apply_reset(input string name);
        reset = 1'b1;
        bus.code_valid = 1'b0;
        bus.code = 8'h00;
        bus.game_over = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check(6'b000_00_0, 1, name);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        bus.code_valid = 1'b0;
        bus.code = 8'h00;
        bus.game_over = 1'b0;
        m_cyc = 0;
        model_reset();

        apply_reset("reset");

        tbl.push_back(row(1, 8'h29, 0, 0, 1, 0, 2'd1, 1, 1)); // start
        tbl.push_back(row(1, 8'hF0, 0, 0, 0, 0, 2'd1, 1, 0));
        tbl.push_back(row(1, 8'h29, 0, 0, 0, 0, 2'd1, 0, 1));
        tbl.push_back(row(1, 8'h29, 0, 1, 0, 0, 2'd1, 1, 1)); // flap
        tbl.push_back(row(1, 8'h29, 0, 0, 0, 0, 2'd1, 1, 1)); // typematic
        tbl.push_back(row(1, 8'h29, 0, 0, 0, 0, 2'd1, 1, 1));
        tbl.push_back(row(1, 8'hF0, 0, 0, 0, 0, 2'd1, 1, 0));
        tbl.push_back(row(1, 8'h29, 0, 0, 0, 0, 2'd1, 0, 1));
        tbl.push_back(row(1, 8'h29, 0, 0, 0, 0, 2'd1, 1, 1)); // cooldown drop
        tbl.push_back(row(1, 8'hF0, 0, 0, 0, 0, 2'd1, 1, 0));
        tbl.push_back(row(1, 8'h29, 0, 0, 0, 0, 2'd1, 0, 1));
        tbl.push_back(row(1, 8'h29, 0, 1, 0, 0, 2'd1, 1, 1)); // counter exactly 0
        tbl.push_back(row(1, 8'hF0, 0, 0, 0, 0, 2'd1, 1, 0));
        tbl.push_back(row(1, 8'h29, 0, 0, 0, 0, 2'd1, 0, 1));
        tbl.push_back(row(1, 8'hE0, 0, 0, 0, 0, 2'd1, 0, 0));
        tbl.push_back(row(1, 8'h29, 0, 0, 0, 0, 2'd1, 0, 1)); // extended make
        tbl.push_back(row(1, 8'hE0, 0, 0, 0, 0, 2'd1, 0, 0));
        tbl.push_back(row(1, 8'hF0, 0, 0, 0, 0, 2'd1, 0, 0));
        tbl.push_back(row(1, 8'h29, 0, 0, 0, 0, 2'd1, 0, 1)); // extended break
        tbl.push_back(row(1, 8'h29, 0, 1, 0, 0, 2'd1, 1, 1));
        tbl.push_back(row(1, 8'h4D, 0, 0, 0, 0, 2'd2, 1, 1)); // pause
        tbl.push_back(row(1, 8'hF0, 0, 0, 0, 0, 2'd2, 1, 0));
        tbl.push_back(row(1, 8'h29, 0, 0, 0, 0, 2'd2, 0, 1));
        tbl.push_back(row(1, 8'h29, 0, 0, 0, 0, 2'd2, 1, 1)); // space ignored
        tbl.push_back(row(1, 8'h4D, 0, 0, 0, 0, 2'd2, 1, 1)); // pause repeat
        tbl.push_back(row(1, 8'hF0, 0, 0, 0, 0, 2'd2, 1, 0));
        tbl.push_back(row(1, 8'h4D, 0, 0, 0, 0, 2'd2, 1, 1));
        tbl.push_back(row(1, 8'h4D, 1, 0, 0, 0, 2'd1, 1, 1)); // resume, game_over ignored
        tbl.push_back(row(1, 8'hF0, 0, 0, 0, 0, 2'd1, 1, 0));
        tbl.push_back(row(1, 8'h29, 0, 0, 0, 0, 2'd1, 0, 1));
        tbl.push_back(row(1, 8'h29, 1, 0, 0, 0, 2'd3, 1, 1)); // over beats flap
        tbl.push_back(row(1, 8'h5A, 1, 0, 0, 1, 2'd0, 1, 1)); // restart
        tbl.push_back(row(1, 8'hF0, 0, 0, 0, 0, 2'd0, 1, 0));
        tbl.push_back(row(1, 8'h29, 0, 0, 0, 0, 2'd0, 0, 1));
        tbl.push_back(row(1, 8'h29, 0, 0, 1, 0, 2'd1, 1, 1));
        tbl.push_back(row(0, 8'h29, 0, 0, 0, 0, 2'd1, 1, 1)); // no strobe, no action

        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i].v, tbl[i].c, tbl[i].go, tbl[i].exp, tbl[i].idle, $sformatf("table[%0d]", i));

        // Reset while a break prefix is pending must drop it.
        apply_reset("reset2");
        step(1, 8'hF0, 0, 6'b000_00_0, 0, "mid_prefix_f0");
        apply_reset("reset_mid_prefix");
        step(1, 8'h29, 0, 6'b010_01_1, 1, "after_reset_make");

        // Random streams against the model.
        apply_reset("reset_random");
        for (int n = 0; n < 600; n++) begin
            logic       v, go;
            logic [7:0] c;
            int         sel;
            v   = ($urandom_range(0, 3) != 0);
            go  = ($urandom_range(0, 15) == 0);
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2: c = 8'h29;
                3:       c = 8'h4D;
                4:       c = 8'h5A;
                5, 6:    c = 8'hF0;
                7:       c = 8'hE0;
                default: c = 8'($urandom_range(0, 255));
            endcase
            model_step(v, c, go);
            exp_q.push_back({m_flap, m_start, m_restart, 2'(m_state), m_held[8'h29]});
            step(v, c, go, exp_q.pop_front(), (m_brk || m_ext) ? 0 : 1, $sformatf("random[%0d]", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
